regfile_mp: RTL and testbench



---
 rtl/regfile_mp_pkg.sv | 20 ++
 rtl/regfile_mp_if.sv | 31 +++
 rtl/regfile_mp_clear_seq.sv | 53 +++++
 rtl/regfile_mp.sv | 112 +++++++++++
 tb/tb_regfile_mp.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared types and default sizing for the CGRA PE multi-port register file.
// Defaults mirror the PE build: 8-bit phit, 2 SIMD lanes, 12 entries.
package cgra_rf_pkg;

  localparam int phit_size    = 8;
  localparam int SIMD_degree  = 2;
  localparam int depth_RF     = 12;
  localparam int dwidth_RFadd = 4;

  typedef struct packed {
    logic [SIMD_degree-1:0] tlast;
    logic [phit_size-1:0]   data;
  } rf_entry_t;

  typedef enum logic {
    RF_CLEAR,
    RF_IDLE
  } rf_state_e;

endpackage

// File: rtl/regfile_mp_if.sv
// Read/write bus bundle of regfile_mp; the master drives requests and the
// slave (the register file) returns registered read results.
interface regfile_mp_if #(
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2,
  parameter int AW     = cgra_rf_pkg::dwidth_RFadd,
  parameter int DW     = cgra_rf_pkg::phit_size,
  parameter int LW     = cgra_rf_pkg::SIMD_degree
);

  logic [NUM_WR-1:0]    wr_en;
  logic [NUM_WR*AW-1:0] wr_addr;
  logic [NUM_WR*DW-1:0] wr_data;
  logic [NUM_WR*LW-1:0] wr_tlast;
  logic [NUM_RD-1:0]    rd_en;
  logic [NUM_RD*AW-1:0] rd_addr;
  logic [NUM_RD*DW-1:0] rd_data;
  logic [NUM_RD*LW-1:0] rd_tlast;
  logic [NUM_RD-1:0]    rd_valid;

  modport master (
    output wr_en, wr_addr, wr_data, wr_tlast, rd_en, rd_addr,
    input  rd_data, rd_tlast, rd_valid
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_tlast, rd_en, rd_addr,
    output rd_data, rd_tlast, rd_valid
  );

endinterface

// File: rtl/regfile_mp_clear_seq.sv
// Clear sequencer: walks ptr over every entry after reset or a clr pulse,
// emitting one zeroing write per cycle while busy.
module rf_clear_seq
  import cgra_rf_pkg::*;
#(
  parameter int DEPTH = depth_RF,
  parameter int AW    = dwidth_RFadd
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  output logic          busy_o,
  output logic          clearWe_o,
  output logic [AW-1:0] clearAddr_o
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  rf_state_e     state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (clr_i) begin
      state_d = RF_CLEAR;
      ptr_d   = '0;
    end else if (state_q == RF_CLEAR) begin
      if (ptr_q == LAST) begin
        state_d = RF_IDLE;
        ptr_d   = '0;
      end else begin
        ptr_d = ptr_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RF_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // busy also covers the reset window itself, before the first clear edge
  assign busy_o      = !rst_n || (state_q == RF_CLEAR);
  assign clearWe_o   = rst_n && (state_q == RF_CLEAR);
  assign clearAddr_o = ptr_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port PE register file with valid scoreboard and hardware clear.
// Define REGFILE_BYPASS_EN to forward same-edge writes to colliding reads.
module regfile_mp
  import cgra_rf_pkg::*;
#(
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2,
  parameter int DEPTH  = depth_RF,
  parameter int AW     = dwidth_RFadd,
  parameter int DW     = phit_size,
  parameter int LW     = SIMD_degree
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  output logic        busy,
  regfile_mp_if.slave bus
);

  localparam int EW = LW + DW;
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  logic [EW-1:0]     mem_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [EW-1:0]     rdEntry_q [NUM_RD];
  logic [EW-1:0]     rdEntry_d [NUM_RD];
  logic [NUM_RD-1:0] rdValid_q, rdValid_d;
  logic [AW-1:0]     rdAddr [NUM_RD];
  logic [AW-1:0]     wrAddr [NUM_WR];
  logic [EW-1:0]     wrEntry [NUM_WR];
  logic [NUM_WR-1:0] wrOk;
  logic              clearWe;
  logic [AW-1:0]     clearAddr;

  function automatic logic inRange(input logic [AW-1:0] a);
    return {1'b0, a} < DEPTH_W;
  endfunction

  rf_clear_seq #(.DEPTH(DEPTH), .AW(AW)) uClearSeq (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (clr),
    .busy_o     (busy),
    .clearWe_o  (clearWe),
    .clearAddr_o(clearAddr)
  );

  for (genvar p = 0; p < NUM_RD; p++) begin : gRdPort
    assign rdAddr[p]                   = bus.rd_addr[p*AW +: AW];
    assign bus.rd_data[p*DW +: DW]     = rdEntry_q[p][DW-1:0];
    assign bus.rd_tlast[p*LW +: LW]    = rdEntry_q[p][EW-1:DW];
  end
  assign bus.rd_valid = rdValid_q;

  // writes are dropped during clear, on a clr edge and when out of range
  for (genvar w = 0; w < NUM_WR; w++) begin : gWrPort
    assign wrAddr[w]  = bus.wr_addr[w*AW +: AW];
    assign wrEntry[w] = {bus.wr_tlast[w*LW +: LW], bus.wr_data[w*DW +: DW]};
    assign wrOk[w]    = rst_n && !clearWe && !clr && bus.wr_en[w] && inRange(wrAddr[w]);
  end

  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      rdEntry_d[p] = rdEntry_q[p];
      rdValid_d[p] = rdValid_q[p];
      if (bus.rd_en[p]) begin
        rdEntry_d[p] = '0;
        rdValid_d[p] = 1'b0;
        if (!clearWe && inRange(rdAddr[p])) begin
          rdEntry_d[p] = mem_q[rdAddr[p]];
          rdValid_d[p] = valid_q[rdAddr[p]];
`ifdef REGFILE_BYPASS_EN
          // ascending scan so the highest-index writer is forwarded
          for (int w = 0; w < NUM_WR; w++) begin
            if (wrOk[w] && (wrAddr[w] == rdAddr[p])) begin
              rdEntry_d[p] = wrEntry[w];
              rdValid_d[p] = 1'b1;
            end
          end
`endif
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q   <= '0;
      rdValid_q <= '0;
      for (int p = 0; p < NUM_RD; p++) rdEntry_q[p] <= '0;
    end else begin
      rdValid_q <= rdValid_d;
      for (int p = 0; p < NUM_RD; p++) rdEntry_q[p] <= rdEntry_d[p];
      if (clr) begin
        valid_q <= '0;
      end else begin
        for (int w = 0; w < NUM_WR; w++) begin
          if (wrOk[w]) valid_q[wrAddr[w]] <= 1'b1;
        end
      end
    end
  end

  // array is zeroed by the sequencer, so it carries no reset; later ports win
  always_ff @(posedge clk) begin
    if (clearWe) mem_q[clearAddr] <= '0;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wrOk[w]) mem_q[wrAddr[w]] <= wrEntry[w];
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: stimulus pushes expected reads, a monitor
// pops and compares them one cycle after each enabled read port.
module tb_regfile_mp;
  import cgra_rf_pkg::*;

  localparam int NRD = 2;
  localparam int NWR = 2;
  localparam int DEP = 12;
  localparam int AWD = 4;
  localparam int DWD = 8;
  localparam int LWD = 2;

  typedef struct {
    int          port;
    logic [10:0] word;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic clr;
  logic busy;
  int   checks = 0;
  int   errors = 0;
  exp_t expQ[$];

  regfile_mp_if #(.NUM_RD(NRD), .NUM_WR(NWR), .AW(AWD), .DW(DWD), .LW(LWD)) bus ();

  regfile_mp #(
    .NUM_RD(NRD), .NUM_WR(NWR), .DEPTH(DEP), .AW(AWD), .DW(DWD), .LW(LWD)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .busy (busy),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  task automatic applyStimulus(
    input logic [1:0] we,
    input logic [3:0] wa0, input logic [7:0] wd0, input logic [1:0] wt0,
    input logic [3:0] wa1, input logic [7:0] wd1, input logic [1:0] wt1,
    input logic [1:0] re, input logic [3:0] ra0, input logic [3:0] ra1
  );
    @(negedge clk);
    bus.wr_en    = we;
    bus.wr_addr  = {wa1, wa0};
    bus.wr_data  = {wd1, wd0};
    bus.wr_tlast = {wt1, wt0};
    bus.rd_en    = re;
    bus.rd_addr  = {ra1, ra0};
  endtask

  task automatic idle();
    applyStimulus(2'b00, 4'd0, 8'h00, 2'b00, 4'd0, 8'h00, 2'b00, 2'b00, 4'd0, 4'd0);
  endtask

  task automatic expectRead(input int port, input logic [7:0] d, input logic [1:0] t,
                            input logic v, input string name);
    exp_t      e;
    rf_entry_t ent;
    ent.tlast = t;
    ent.data  = d;
    e.port    = port;
    e.word    = {v, ent};
    e.name    = name;
    expQ.push_back(e);
  endtask

  task automatic measureBusy(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (!busy) return;
      n++;
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("[TB] FAIL busyTimeout got busy stuck high required drop within 100 cycles");
  endtask

  // monitor: any port enabled at an edge owes one scoreboard entry just after it
  initial begin
    logic [1:0]  en;
    logic [10:0] act;
    exp_t        e;
    forever begin
      @(posedge clk);
      en = bus.rd_en;
      #1;
      for (int p = 0; p < NRD; p++) begin
        if (en[p]) begin
          act = {bus.rd_valid[p], bus.rd_tlast[p*LWD +: LWD], bus.rd_data[p*DWD +: DWD]};
          if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpectedRead port %0d got 0x%0h required no read", p, act);
          end else begin
            e = expQ.pop_front();
            checkOutput($sformatf("%s_p%0d", e.name, e.port), int'(act), int'(e.word));
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog got no finish required finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int m;
    rst_n = 1'b0;
    clr   = 1'b0;
    bus.wr_en = '0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_tlast = '0;
    bus.rd_en = '0; bus.rd_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("resetBusy", int'(busy), 1);
    checkOutput("resetRdValid", int'(bus.rd_valid), 0);
    checkOutput("resetRdData", int'(bus.rd_data), 0);
    checkOutput("resetRdTlast", int'(bus.rd_tlast), 0);

    rst_n = 1'b1;
    measureBusy(n);
    checkOutput("resetBusyCycles", n, DEP);

    for (int i = 0; i < DEP; i++) begin
      applyStimulus(2'b00, 4'd0, 8'h00, 2'b00, 4'd0, 8'h00, 2'b00, 2'b11, 4'(i), 4'(DEP - 1 - i));
      expectRead(0, 8'h00, 2'b00, 1'b0, $sformatf("clearedRd%0d", i));
      expectRead(1, 8'h00, 2'b00, 1'b0, $sformatf("clearedRd%0d", DEP - 1 - i));
    end
    idle();

    applyStimulus(2'b01, 4'd3, 8'hAB, 2'b01, 4'd0, 8'h00, 2'b00, 2'b00, 4'd0, 4'd0);
    applyStimulus(2'b00, 4'd0, 8'h00, 2'b00, 4'd0, 8'h00, 2'b00, 2'b01, 4'd3, 4'd0);
    expectRead(0, 8'hAB, 2'b01, 1'b1, "writeRead3");

    // port 0 output must hold AB while disabled, even though addr 3 changes
    applyStimulus(2'b01, 4'd3, 8'hCD, 2'b00, 4'd0, 8'h00, 2'b00, 2'b00, 4'd0, 4'd0);
    idle();
    checkOutput("holdRd", int'({bus.rd_valid[0], bus.rd_data[7:0]}), 'h1AB);
    applyStimulus(2'b00, 4'd0, 8'h00, 2'b00, 4'd0, 8'h00, 2'b00, 2'b01, 4'd3, 4'd0);
    expectRead(0, 8'hCD, 2'b00, 1'b1, "overwrite3");

    applyStimulus(2'b11, 4'd5, 8'h11, 2'b00, 4'd5, 8'h22, 2'b10, 2'b00, 4'd0, 4'd0);
    applyStimulus(2'b00, 4'd0, 8'h00, 2'b00, 4'd0, 8'h00, 2'b00, 2'b10, 4'd0, 4'd5);
    expectRead(1, 8'h22, 2'b10, 1'b1, "writeConflict5");

    applyStimulus(2'b01, 4'd7, 8'h10, 2'b00, 4'd0, 8'h00, 2'b00, 2'b00, 4'd0, 4'd0);
    applyStimulus(2'b01, 4'd7, 8'h55, 2'b11, 4'd0, 8'h00, 2'b00, 2'b01, 4'd7, 4'd0);
`ifdef REGFILE_BYPASS_EN
    expectRead(0, 8'h55, 2'b11, 1'b1, "collide7");
`else
    expectRead(0, 8'h10, 2'b00, 1'b1, "collide7");
`endif
    applyStimulus(2'b00, 4'd0, 8'h00, 2'b00, 4'd0, 8'h00, 2'b00, 2'b01, 4'd7, 4'd0);
    expectRead(0, 8'h55, 2'b11, 1'b1, "afterCollide7");

    applyStimulus(2'b11, 4'd8, 8'h66, 2'b01, 4'd8, 8'h77, 2'b10, 2'b01, 4'd8, 4'd0);
`ifdef REGFILE_BYPASS_EN
    expectRead(0, 8'h77, 2'b10, 1'b1, "collideBoth8");
`else
    expectRead(0, 8'h00, 2'b00, 1'b0, "collideBoth8");
`endif
    applyStimulus(2'b00, 4'd0, 8'h00, 2'b00, 4'd0, 8'h00, 2'b00, 2'b01, 4'd8, 4'd0);
    expectRead(0, 8'h77, 2'b10, 1'b1, "afterCollideBoth8");

    applyStimulus(2'b01, 4'd13, 8'hEE, 2'b11, 4'd0, 8'h00, 2'b00, 2'b10, 4'd0, 4'd13);
    expectRead(1, 8'h00, 2'b00, 1'b0, "outOfRangeSame13");
    applyStimulus(2'b00, 4'd0, 8'h00, 2'b00, 4'd0, 8'h00, 2'b00, 2'b11, 4'd13, 4'd1);
    expectRead(0, 8'h00, 2'b00, 1'b0, "outOfRange13");
    expectRead(1, 8'h00, 2'b00, 1'b0, "noAlias1");

    // start a clear, then restart it with a second clr on its fourth cycle
    idle();
    clr = 1'b1;
    idle();
    clr = 1'b0;
    bus.rd_en   = 2'b01;
    bus.rd_addr = 8'h03;
    expectRead(0, 8'h00, 2'b00, 1'b0, "readDuringClear");
    #1 checkOutput("midClearBusy0", int'(busy), 1);
    for (int k = 1; k <= 3; k++) begin
      idle();
      clr = (k == 3);
      #1 checkOutput($sformatf("midClearBusy%0d", k), int'(busy), 1);
    end
    applyStimulus(2'b01, 4'd9, 8'h99, 2'b01, 4'd0, 8'h00, 2'b00, 2'b00, 4'd0, 4'd0);
    clr = 1'b0;
    n = 0;
    #1 if (busy) n++;
    idle();
    measureBusy(m);
    checkOutput("restartBusyCycles", n + m, DEP);

    applyStimulus(2'b00, 4'd0, 8'h00, 2'b00, 4'd0, 8'h00, 2'b00, 2'b11, 4'd9, 4'd3);
    expectRead(0, 8'h00, 2'b00, 1'b0, "droppedMidClear9");
    expectRead(1, 8'h00, 2'b00, 1'b0, "clearedAfterClr3");
    repeat (3) idle();
    checkOutput("noWrapBusy", int'(busy), 0);

    repeat (3) idle();
    checkOutput("scoreboardDrained", expQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
